tlb_op_ctrl: RTL and testbench
==============================

Name: tlb_op_ctrl

Overview:
Sequences the TLB management instructions TLBP, TLBR and TLBWI against the 16-entry TLB, which provides search, read and write ports. Owns the CP0 Index, EntryHi, EntryLo0 and EntryLo1 registers. Sits beside the write-back stage and CP0 logic: WB hands it one TLB op at a time, and MTC0/MFC0 use its CP0 register port. On completion of each op it pulses a refetch request so the pipeline restarts with the updated mapping.

Parameters:
TLBNUM, 16, number of TLB entries
IDX_W, 4, index width (log2 TLBNUM)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
op_valid  in  1  TLB op request from WB
op_code  in  2  01=TLBP, 10=TLBR, 11=TLBWI; 00 ignored (treated as no request)
op_ready  out  1  op accepted when op_valid&&op_ready
op_done  out  1  one-cycle completion pulse
refetch  out  1  one-cycle pulse, coincident with op_done
flush  in  1  exception/ERET flush; aborts an in-flight op
cp0_wen  in  1  MTC0 write strobe
cp0_addr  in  5  CP0 reg number: 0 Index, 2 Lo0, 3 Lo1, 10 EntryHi
cp0_wdata  in  32  MTC0 data
cp0_ready  out  1  write accepted when cp0_wen&&cp0_ready
cp0_rdata  out  32  combinational read of the register selected by cp0_addr; 0 for other addresses
entryhi_asid  out  8  current ASID, for the fetch/mem lookups
s_vpn2 / s_asid  out  19/8  search key
s_found / s_index  in  1/IDX_W  search result, combinational from key
r_index  out  IDX_W  read index
r_vpn2,r_asid,r_g,r_pfn0,r_c0,r_d0,r_v0,r_pfn1,r_c1,r_d1,r_v1  in  19,8,1,20,3,1,1,20,3,1,1  read data, combinational from r_index
we  out  1  TLB write strobe
w_index,w_vpn2,w_asid,w_g,w_pfn0,w_c0,w_d0,w_v0,w_pfn1,w_c1,w_d1,w_v1  out  IDX_W,19,8,1,20,3,1,1,20,3,1,1  write data

Behaviour:
- Register layouts:
  - Index: {P[31], 0[30:IDX_W], idx}.
  - EntryHi: {VPN2[31:13], 0[12:8], ASID[7:0]}.
  - EntryLo: {0[31:26], PFN[25:6], C[5:3], D[2], V[1], G[0]}.
- Reset: all four registers 0; state IDLE; op_done=refetch=we=0; op_ready=!cp0_wen; cp0_ready=1.
- MTC0 write masks:
  - Index: writes idx only; P is read-only.
  - EntryHi: writes [31:13] and [7:0].
  - EntryLo0/1: writes [25:0].
  - Any other address: ignored.
- FSM states: IDLE, PROBE, READ, WRITE, DONE.
- IDLE:
  - cp0_ready=1.
  - op_ready=!cp0_wen. MTC0 has priority: an op presented in the same cycle waits.
  - On op accept, go to PROBE, READ or WRITE by op_code.
- PROBE:
  - Drive s_vpn2/s_asid from EntryHi.
  - Capture at the clock edge: P<=!s_found; idx<=s_index if found, else unchanged.
  - Next state DONE.
- READ:
  - r_index=Index.idx.
  - Capture: EntryHi<={r_vpn2,0,r_asid}.
  - EntryLo0<={r_pfn0,r_c0,r_d0,r_v0,r_g}; EntryLo1<={r_pfn1,r_c1,r_d1,r_v1,r_g}.
  - Next state DONE.
- WRITE:
  - we=1 for exactly this cycle.
  - w_index=Index.idx; w_vpn2/w_asid from EntryHi; w_g=Lo0.G & Lo1.G; remaining fields from Lo0/Lo1.
  - Next state DONE.
- DONE: op_done=refetch=1 for one cycle, then IDLE.
- Latency: accept at cycle N, action at N+1, done pulse at N+2. Back-to-back ops: next op accepted at N+3.
- Busy: op_ready=cp0_ready=0 in every non-IDLE state. An MTC0 presented while busy is held by the requester until IDLE.
- Flush:
  - In PROBE/READ/WRITE: go to IDLE; no register update, we forced 0, no op_done/refetch.
  - In DONE: pulse still issued.
  - In IDLE: no effect.
- Reset mid-op: returns to IDLE immediately; we=0 in that cycle.
- s_vpn2/s_asid track EntryHi continuously. r_index/w_index track Index.idx continuously. Only we is gated.
- entryhi_asid=EntryHi[7:0], updated by MTC0 or TLBR.

Test Plan:
1. MTC0 EntryHi=0x0040_2005, Lo0=0x0000_1046, Lo1=0x0000_1087, Index=3; TLBWI -> at N+1 we=1 (single cycle), w_index=3, w_vpn2=0x0201, w_asid=0x05, w_pfn0=0x41, w_g=0; op_done+refetch at N+2.
2. TLBP with s_found=1, s_index=3 -> Index reads 0x0000_0003. TLBP with s_found=0 -> Index reads 0x8000_0003 (idx kept).
3. TLBR, Index=3, TLB returns vpn2=0x7FFFF, asid=0xAA, g=1, pfn0=0xFFFFF -> EntryHi=0xFFFF_E0AA, Lo0=0x03FF_FFC1|{c0,d0,v0} bits, entryhi_asid=0xAA.
4. op_valid and cp0_wen asserted in the same IDLE cycle -> the MTC0 write lands, op_ready=0 that cycle, op accepted the next cycle.
5. flush asserted in the WRITE cycle -> we=0, no op_done, state IDLE, op_ready=1 the next cycle. Reset asserted in the PROBE cycle -> Index=0, no pulse.
6. MTC0 Index=0xFFFF_FFFF -> reads 0x0000_000F. MTC0 EntryLo0=0xFFFF_FFFF -> reads 0x03FF_FFFF. MTC0 issued while in READ -> cp0_ready=0, write lands only after DONE.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// TLB management sequencer for TLBP/TLBR/TLBWI. Owns CP0 Index, EntryHi,
// EntryLo0 and EntryLo1, and pulses op_done/refetch when each op completes.
//
// state   | meaning
// IDLE    | accepts MTC0 writes (priority) or one TLB op
// PROBE   | search TLB with EntryHi, capture P/idx into Index
// READ    | read TLB[Index.idx] into EntryHi/EntryLo0/EntryLo1
// WRITE   | write EntryHi/EntryLo0/EntryLo1 into TLB[Index.idx]
// DONE    | op_done/refetch pulse, then IDLE
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = $clog2(TLBNUM)
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             op_valid,
  input  logic [1:0]       op_code,
  output logic             op_ready,
  output logic             op_done,
  output logic             refetch,
  input  logic             flush,

  input  logic             cp0_wen,
  input  logic [4:0]       cp0_addr,
  input  logic [31:0]      cp0_wdata,
  output logic             cp0_ready,
  output logic [31:0]      cp0_rdata,
  output logic [7:0]       entryhi_asid,

  output logic [18:0]      s_vpn2,
  output logic [7:0]       s_asid,
  input  logic             s_found,
  input  logic [IDX_W-1:0] s_index,

  output logic [IDX_W-1:0] r_index,
  input  logic [18:0]      r_vpn2,
  input  logic [7:0]       r_asid,
  input  logic             r_g,
  input  logic [19:0]      r_pfn0,
  input  logic [2:0]       r_c0,
  input  logic             r_d0,
  input  logic             r_v0,
  input  logic [19:0]      r_pfn1,
  input  logic [2:0]       r_c1,
  input  logic             r_d1,
  input  logic             r_v1,

  output logic             we,
  output logic [IDX_W-1:0] w_index,
  output logic [18:0]      w_vpn2,
  output logic [7:0]       w_asid,
  output logic             w_g,
  output logic [19:0]      w_pfn0,
  output logic [2:0]       w_c0,
  output logic             w_d0,
  output logic             w_v0,
  output logic [19:0]      w_pfn1,
  output logic [2:0]       w_c1,
  output logic             w_d1,
  output logic             w_v1
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PROBE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [4:0] A_INDEX   = 5'd0;
  localparam logic [4:0] A_LO0     = 5'd2;
  localparam logic [4:0] A_LO1     = 5'd3;
  localparam logic [4:0] A_ENTRYHI = 5'd10;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             idx_p;
  logic [IDX_W-1:0] idx;
  logic [18:0]      hi_vpn2;
  logic [7:0]       hi_asid;
  logic [25:0]      lo0;
  logic [25:0]      lo1;

  logic is_idle;
  logic op_go;
  logic cp0_go;
  logic unused_wdata;

  assign is_idle   = (state == S_IDLE);
  assign op_ready  = is_idle && !cp0_wen;
  assign cp0_ready = is_idle;
  assign op_go     = op_valid && op_ready && (op_code != 2'b00);
  assign cp0_go    = cp0_wen && cp0_ready;

  // EntryHi[12:8] is hard-wired zero, so those write bits are never stored.
  assign unused_wdata = ^cp0_wdata[12:8];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (op_go) begin
          case (op_code)
            2'b01:   state_nxt = S_PROBE;
            2'b10:   state_nxt = S_READ;
            default: state_nxt = S_WRITE;
          endcase
        end
      end
      S_PROBE, S_READ, S_WRITE: state_nxt = flush ? S_IDLE : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      idx_p   <= 1'b0;
      idx     <= '0;
      hi_vpn2 <= '0;
      hi_asid <= '0;
      lo0     <= '0;
      lo1     <= '0;
    end else begin
      state <= state_nxt;
      if (cp0_go) begin
        case (cp0_addr)
          A_INDEX:   idx <= cp0_wdata[IDX_W-1:0];
          A_LO0:     lo0 <= cp0_wdata[25:0];
          A_LO1:     lo1 <= cp0_wdata[25:0];
          A_ENTRYHI: begin
            hi_vpn2 <= cp0_wdata[31:13];
            hi_asid <= cp0_wdata[7:0];
          end
          default: ;
        endcase
      end
      if (state == S_PROBE && !flush) begin
        idx_p <= !s_found;
        if (s_found) idx <= s_index;
      end
      if (state == S_READ && !flush) begin
        hi_vpn2 <= r_vpn2;
        hi_asid <= r_asid;
        lo0     <= {r_pfn0, r_c0, r_d0, r_v0, r_g};
        lo1     <= {r_pfn1, r_c1, r_d1, r_v1, r_g};
      end
    end
  end

  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0_addr)
      A_INDEX:   cp0_rdata = {idx_p, {(31-IDX_W){1'b0}}, idx};
      A_LO0:     cp0_rdata = {6'b0, lo0};
      A_LO1:     cp0_rdata = {6'b0, lo1};
      A_ENTRYHI: cp0_rdata = {hi_vpn2, 5'b0, hi_asid};
      default:   cp0_rdata = 32'h0;
    endcase
  end

  assign op_done      = (state == S_DONE) && !reset;
  assign refetch      = op_done;
  assign entryhi_asid = hi_asid;

  assign s_vpn2  = hi_vpn2;
  assign s_asid  = hi_asid;
  assign r_index = idx;

  assign we      = (state == S_WRITE) && !flush && !reset;
  assign w_index = idx;
  assign w_vpn2  = hi_vpn2;
  assign w_asid  = hi_asid;
  assign w_g     = lo0[0] & lo1[0];
  assign w_pfn0  = lo0[25:6];
  assign w_c0    = lo0[5:3];
  assign w_d0    = lo0[2];
  assign w_v0    = lo0[1];
  assign w_pfn1  = lo1[25:6];
  assign w_c1    = lo1[5:3];
  assign w_d1    = lo1[2];
  assign w_v1    = lo1[1];

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed testbench for tlb_op_ctrl: drives on the falling edge, samples 1ns later.
module tb_tlb_op_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [1:0]  op_code;
  logic        op_ready, op_done, refetch;
  logic        flush;
  logic        cp0_wen;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        cp0_ready;
  logic [31:0] cp0_rdata;
  logic [7:0]  entryhi_asid;
  logic [18:0] s_vpn2;
  logic [7:0]  s_asid;
  logic        s_found;
  logic [3:0]  s_index;
  logic [3:0]  r_index;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;
  logic        r_d0, r_v0, r_d1, r_v1;
  logic        we;
  logic [3:0]  w_index;
  logic [18:0] w_vpn2;
  logic [7:0]  w_asid;
  logic        w_g;
  logic [19:0] w_pfn0, w_pfn1;
  logic [2:0]  w_c0, w_c1;
  logic        w_d0, w_v0, w_d1, w_v1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlb_op_ctrl dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .op_done(op_done), .refetch(refetch), .flush(flush),
    .cp0_wen(cp0_wen), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .cp0_ready(cp0_ready), .cp0_rdata(cp0_rdata), .entryhi_asid(entryhi_asid),
    .s_vpn2(s_vpn2), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1)
  );

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    cp0_wen = 1'b1; cp0_addr = addr; cp0_wdata = data;
    @(posedge clk);
    #1 cp0_wen = 1'b0;
  endtask

  // Presents an op for one cycle; the next falling edge is the action cycle.
  task automatic issue_op(input logic [1:0] code);
    @(negedge clk);
    op_valid = 1'b1; op_code = code;
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 0; op_code = 0; flush = 0; cp0_wen = 0;
    cp0_addr = 0; cp0_wdata = 0; s_found = 0; s_index = 0;
    r_vpn2 = 0; r_asid = 0; r_g = 0; r_pfn0 = 0; r_c0 = 0; r_d0 = 0; r_v0 = 0;
    r_pfn1 = 0; r_c1 = 0; r_d1 = 0; r_v1 = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_op_ready: got %b exp 1", op_ready); end
    checks++; if (cp0_ready !== 1'b1) begin errors++; $display("FAIL rst_cp0_ready: got %b exp 1", cp0_ready); end
    checks++; if ({we, op_done, refetch} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b exp 000", {we, op_done, refetch}); end
    checks++; if (entryhi_asid !== 8'h00) begin errors++; $display("FAIL rst_asid: got %h exp 00", entryhi_asid); end
    for (int a = 0; a < 4; a++) begin
      logic [4:0] addrs [4];
      addrs[0] = 5'd0; addrs[1] = 5'd2; addrs[2] = 5'd3; addrs[3] = 5'd10;
      cp0_addr = addrs[a];
      #1;
      checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL rst_reg%0d: got %h exp 00000000", addrs[a], cp0_rdata); end
    end
  endtask

  task automatic test_tlbwi();
    mtc0(5'd10, 32'h0040_2005);
    mtc0(5'd2,  32'h0000_1046);
    mtc0(5'd3,  32'h0000_1087);
    mtc0(5'd0,  32'h0000_0003);
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b11;
    #1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL wi_accept: got %b exp 1", op_ready); end
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL wi_we: got %b exp 1", we); end
    checks++; if (w_index !== 4'd3) begin errors++; $display("FAIL wi_index: got %h exp 3", w_index); end
    checks++; if (w_vpn2 !== 19'h00201) begin errors++; $display("FAIL wi_vpn2: got %h exp 00201", w_vpn2); end
    checks++; if (w_asid !== 8'h05) begin errors++; $display("FAIL wi_asid: got %h exp 05", w_asid); end
    checks++; if (w_pfn0 !== 20'h00041) begin errors++; $display("FAIL wi_pfn0: got %h exp 00041", w_pfn0); end
    checks++; if (w_g !== 1'b0) begin errors++; $display("FAIL wi_g: got %b exp 0", w_g); end
    checks++; if ({w_c0, w_d0, w_v0} !== 5'b00011) begin errors++; $display("FAIL wi_cdv0: got %b exp 00011", {w_c0, w_d0, w_v0}); end
    checks++; if ({w_pfn1, w_c1, w_d1, w_v1} !== {20'h00042, 5'b00011}) begin errors++; $display("FAIL wi_lo1: got %h exp %h", {w_pfn1, w_c1, w_d1, w_v1}, {20'h00042, 5'b00011}); end
    checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL wi_early_done: got %b exp 0", op_done); end
    @(negedge clk); #1;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL wi_we_single: got %b exp 0", we); end
    checks++; if ({op_done, refetch} !== 2'b11) begin errors++; $display("FAIL wi_done: got %b exp 11", {op_done, refetch}); end
    @(negedge clk); #1;
    checks++; if ({op_done, op_ready} !== 2'b01) begin errors++; $display("FAIL wi_after: got %b exp 01", {op_done, op_ready}); end
  endtask

  task automatic test_tlbp();
    mtc0(5'd0, 32'h0000_0007);
    s_found = 1'b1; s_index = 4'd3;
    issue_op(2'b01);
    @(negedge clk); #1;
    checks++; if ({s_vpn2, s_asid} !== {19'h00201, 8'h05}) begin errors++; $display("FAIL p_key: got %h exp %h", {s_vpn2, s_asid}, {19'h00201, 8'h05}); end
    @(negedge clk); cp0_addr = 5'd0; #1;
    checks++; if (op_done !== 1'b1) begin errors++; $display("FAIL p_done: got %b exp 1", op_done); end
    checks++; if (cp0_rdata !== 32'h0000_0003) begin errors++; $display("FAIL p_hit: got %h exp 00000003", cp0_rdata); end
    s_found = 1'b0; s_index = 4'd9;
    issue_op(2'b01);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (cp0_rdata !== 32'h8000_0003) begin errors++; $display("FAIL p_miss: got %h exp 80000003", cp0_rdata); end
  endtask

  task automatic test_tlbr();
    r_vpn2 = 19'h7FFFF; r_asid = 8'hAA; r_g = 1'b1;
    r_pfn0 = 20'hFFFFF; r_c0 = 3'd5; r_d0 = 1'b1; r_v0 = 1'b0;
    r_pfn1 = 20'h12345; r_c1 = 3'd2; r_d1 = 1'b0; r_v1 = 1'b1;
    issue_op(2'b10);
    @(negedge clk); #1;
    checks++; if (r_index !== 4'd3) begin errors++; $display("FAIL r_index: got %h exp 3", r_index); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL r_we: got %b exp 0", we); end
    @(negedge clk); cp0_addr = 5'd10; #1;
    checks++; if (cp0_rdata !== 32'hFFFF_E0AA) begin errors++; $display("FAIL r_hi: got %h exp FFFFE0AA", cp0_rdata); end
    checks++; if (entryhi_asid !== 8'hAA) begin errors++; $display("FAIL r_asid: got %h exp AA", entryhi_asid); end
    cp0_addr = 5'd2; #1;
    checks++; if (cp0_rdata !== 32'h03FF_FFED) begin errors++; $display("FAIL r_lo0: got %h exp 03FFFFED", cp0_rdata); end
    cp0_addr = 5'd3; #1;
    checks++; if (cp0_rdata !== 32'h0048_D153) begin errors++; $display("FAIL r_lo1: got %h exp 0048D153", cp0_rdata); end
    cp0_addr = 5'd0; #1;
    checks++; if (cp0_rdata !== 32'h8000_0003) begin errors++; $display("FAIL r_index_kept: got %h exp 80000003", cp0_rdata); end
  endtask

  task automatic test_mtc0_priority();
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b01;
    cp0_wen = 1'b1; cp0_addr = 5'd10; cp0_wdata = 32'h1234_7F77;
    #1;
    checks++; if ({op_ready, cp0_ready} !== 2'b01) begin errors++; $display("FAIL pri_ready: got %b exp 01", {op_ready, cp0_ready}); end
    @(negedge clk);
    cp0_wen = 1'b0;
    #1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL pri_op_next: got %b exp 1", op_ready); end
    checks++; if (cp0_rdata !== 32'h1234_6077) begin errors++; $display("FAIL pri_hi_mask: got %h exp 12346077", cp0_rdata); end
    checks++; if ({s_vpn2, s_asid} !== {19'h091A3, 8'h77}) begin errors++; $display("FAIL pri_key: got %h exp %h", {s_vpn2, s_asid}, {19'h091A3, 8'h77}); end
    s_found = 1'b1; s_index = 4'hA;
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    checks++; if ({op_ready, cp0_ready} !== 2'b00) begin errors++; $display("FAIL pri_busy: got %b exp 00", {op_ready, cp0_ready}); end
    @(negedge clk); cp0_addr = 5'd0; #1;
    checks++; if (op_done !== 1'b1) begin errors++; $display("FAIL pri_done: got %b exp 1", op_done); end
    checks++; if (cp0_rdata !== 32'h0000_000A) begin errors++; $display("FAIL pri_index: got %h exp 0000000A", cp0_rdata); end
  endtask

  task automatic test_flush();
    issue_op(2'b11);
    @(negedge clk); flush = 1'b1; #1;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL fl_we: got %b exp 0", we); end
    @(negedge clk); flush = 1'b0; #1;
    checks++; if ({op_done, refetch, op_ready} !== 3'b001) begin errors++; $display("FAIL fl_write_abort: got %b exp 001", {op_done, refetch, op_ready}); end
    s_found = 1'b1; s_index = 4'd2;
    issue_op(2'b01);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; cp0_addr = 5'd0; #1;
    checks++; if ({op_done, op_ready} !== 2'b01) begin errors++; $display("FAIL fl_probe_abort: got %b exp 01", {op_done, op_ready}); end
    checks++; if (cp0_rdata !== 32'h0000_000A) begin errors++; $display("FAIL fl_probe_noupd: got %h exp 0000000A", cp0_rdata); end
    issue_op(2'b01);
    @(negedge clk);
    @(negedge clk); flush = 1'b1; #1;
    checks++; if ({op_done, refetch} !== 2'b11) begin errors++; $display("FAIL fl_done_kept: got %b exp 11", {op_done, refetch}); end
    @(negedge clk); flush = 1'b0; #1;
    checks++; if (cp0_rdata !== 32'h0000_0002) begin errors++; $display("FAIL fl_done_index: got %h exp 00000002", cp0_rdata); end
    issue_op(2'b01);
    @(negedge clk); reset = 1'b1; #1;
    checks++; if ({we, op_done} !== 2'b00) begin errors++; $display("FAIL rs_mid: got %b exp 00", {we, op_done}); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if ({op_done, op_ready} !== 2'b01) begin errors++; $display("FAIL rs_idle: got %b exp 01", {op_done, op_ready}); end
    checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL rs_index: got %h exp 00000000", cp0_rdata); end
  endtask

  task automatic test_masks();
    mtc0(5'd0, 32'hFFFF_FFFF);
    @(negedge clk); cp0_addr = 5'd0; #1;
    checks++; if (cp0_rdata !== 32'h0000_000F) begin errors++; $display("FAIL m_index: got %h exp 0000000F", cp0_rdata); end
    mtc0(5'd2, 32'hFFFF_FFFF);
    @(negedge clk); cp0_addr = 5'd2; #1;
    checks++; if (cp0_rdata !== 32'h03FF_FFFF) begin errors++; $display("FAIL m_lo0: got %h exp 03FFFFFF", cp0_rdata); end
    mtc0(5'd5, 32'hFFFF_FFFF);
    @(negedge clk); cp0_addr = 5'd5; #1;
    checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL m_other: got %h exp 00000000", cp0_rdata); end
    cp0_addr = 5'd3; #1;
    checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL m_lo1_untouched: got %h exp 00000000", cp0_rdata); end
    issue_op(2'b10);
    @(negedge clk);
    cp0_wen = 1'b1; cp0_addr = 5'd0; cp0_wdata = 32'h0000_0005;
    #1;
    checks++; if (cp0_ready !== 1'b0) begin errors++; $display("FAIL m_busy_read: got %b exp 0", cp0_ready); end
    @(negedge clk); #1;
    checks++; if ({cp0_ready, op_done} !== 2'b01) begin errors++; $display("FAIL m_busy_done: got %b exp 01", {cp0_ready, op_done}); end
    checks++; if (cp0_rdata !== 32'h0000_000F) begin errors++; $display("FAIL m_held: got %h exp 0000000F", cp0_rdata); end
    @(negedge clk); #1;
    checks++; if ({cp0_ready, op_ready} !== 2'b10) begin errors++; $display("FAIL m_idle_ready: got %b exp 10", {cp0_ready, op_ready}); end
    @(posedge clk);
    #1 cp0_wen = 1'b0;
    @(negedge clk); #1;
    checks++; if (cp0_rdata !== 32'h0000_0005) begin errors++; $display("FAIL m_landed: got %h exp 00000005", cp0_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rdy, exp_we, exp_done;
    exp_rdy = 4'b1001; exp_we = 4'b0010; exp_done = 4'b0100;
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b00;
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    checks++; if ({we, op_ready} !== 2'b01) begin errors++; $display("FAIL nop_ignored: got %b exp 01", {we, op_ready}); end
    @(negedge clk); #1;
    checks++; if (op_done !== 1'b0) begin errors++; $display("FAIL nop_done: got %b exp 0", op_done); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      op_valid = 1'b1; op_code = 2'b11;
      #1;
      checks++; if ({op_ready, we, op_done} !== {exp_rdy[i], exp_we[i], exp_done[i]}) begin
        errors++; $display("FAIL b2b_cycle%0d: got %b exp %b", i, {op_ready, we, op_done}, {exp_rdy[i], exp_we[i], exp_done[i]});
      end
    end
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL b2b_second_we: got %b exp 1", we); end
    @(negedge clk); #1;
    checks++; if (op_done !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b exp 1", op_done); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_tlbwi();
    test_tlbp();
    test_tlbr();
    test_mtc0_priority();
    test_flush();
    test_masks();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
